mem_access_stage: RTL and testbench

MEM pipeline stage between the EX/MEM latch and the MEM/WB latch. Performs byte, half and word loads and stores against a handshaked data memory. Extracts and extends load data, and stalls the upstream pipeline while an access is outstanding. Results are registered on the stage outputs, which feed the MEM/WB latch directly.

---
 rtl/mem_access_stage.sv | 232 +++++++++++++++++++++++
 tb/tb_mem_access_stage.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues byte/half/word loads and stores on a handshaked data
// memory port, extends load data and stalls upstream while an access is in flight.
module mem_access_stage #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inValid,
    input  logic              inMemRead,
    input  logic              inMemWrite,
    input  logic [1:0]        inMemSize,
    input  logic              inLoadSigned,
    input  logic [ADDR_W-1:0] inAluResult,
    input  logic [DATA_W-1:0] inStoreData,
    input  logic [4:0]        inMuxRtRd,
    input  logic              inRegWrite,
    input  logic [1:0]        inMemtoReg,
    output logic              dmemReq,
    output logic              dmemWe,
    output logic [ADDR_W-1:0] dmemAddr,
    output logic [DATA_W-1:0] dmemWdata,
    output logic [3:0]        dmemByteEn,
    input  logic [DATA_W-1:0] dmemRdata,
    input  logic              dmemAck,
    output logic              outStall,
    output logic              outValid,
    output logic [DATA_W-1:0] outLoadWordDividerMEM,
    output logic [31:0]       outAluLatch,
    output logic [4:0]        outMuxRtRd,
    output logic              outRegWrite,
    output logic [1:0]        outMemtoReg,
    output logic              outMisaligned
);

    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned REG_W = 5;
    localparam int unsigned M2R_W = 2;

    typedef enum logic [0:0] {IDLE, ACCESS} state_t;

    state_t state_q, state_d;

    // Request fields captured when an access is launched
    logic              req_we_q, req_we_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic [1:0]        req_size_q, req_size_d;
    logic              req_signed_q, req_signed_d;
    logic [DATA_W-1:0] req_wdata_q, req_wdata_d;
    logic [BE_W-1:0]   req_be_q, req_be_d;
    logic [REG_W-1:0]  req_rd_q, req_rd_d;
    logic              req_rw_q, req_rw_d;
    logic [M2R_W-1:0]  req_m2r_q, req_m2r_d;

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_load_q, out_load_d;
    logic [31:0]       out_alu_q, out_alu_d;
    logic [REG_W-1:0]  out_rd_q, out_rd_d;
    logic              out_rw_q, out_rw_d;
    logic [M2R_W-1:0]  out_m2r_q, out_m2r_d;
    logic              out_mis_q, out_mis_d;

    logic              is_mem_c;
    logic              mis_c;
    logic              start_c;
    logic              stall_c;
    logic [BE_W-1:0]   st_be_c;
    logic [DATA_W-1:0] st_wdata_c;
    logic [7:0]        ld_byte_c;
    logic [15:0]       ld_half_c;
    logic [DATA_W-1:0] ld_ext_c;

    // Alignment check and little-endian store lane placement from the incoming op
    always_comb begin
        is_mem_c   = inValid & (inMemRead | inMemWrite);
        mis_c      = 1'b0;
        st_be_c    = '1;
        st_wdata_c = inStoreData;
        case (inMemSize)
            2'b00: begin
                st_be_c    = BE_W'(1) << inAluResult[1:0];
                st_wdata_c = {4{inStoreData[7:0]}};
            end
            2'b01: begin
                mis_c      = is_mem_c & inAluResult[0];
                st_be_c    = inAluResult[1] ? 4'b1100 : 4'b0011;
                st_wdata_c = {2{inStoreData[15:0]}};
            end
            default: begin
                mis_c = is_mem_c & (|inAluResult[1:0]);
            end
        endcase
        start_c = is_mem_c & ~mis_c;
    end

    // Lane select and extension of returned read data
    always_comb begin
        case (req_addr_q[1:0])
            2'b00:   ld_byte_c = dmemRdata[7:0];
            2'b01:   ld_byte_c = dmemRdata[15:8];
            2'b10:   ld_byte_c = dmemRdata[23:16];
            default: ld_byte_c = dmemRdata[31:24];
        endcase
        ld_half_c = req_addr_q[1] ? dmemRdata[31:16] : dmemRdata[15:0];
        case (req_size_q)
            2'b00:   ld_ext_c = req_signed_q ? {{24{ld_byte_c[7]}}, ld_byte_c} : {24'b0, ld_byte_c};
            2'b01:   ld_ext_c = req_signed_q ? {{16{ld_half_c[15]}}, ld_half_c} : {16'b0, ld_half_c};
            default: ld_ext_c = dmemRdata;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        stall_c      = 1'b0;
        req_we_d     = req_we_q;
        req_addr_d   = req_addr_q;
        req_size_d   = req_size_q;
        req_signed_d = req_signed_q;
        req_wdata_d  = req_wdata_q;
        req_be_d     = req_be_q;
        req_rd_d     = req_rd_q;
        req_rw_d     = req_rw_q;
        req_m2r_d    = req_m2r_q;
        out_valid_d  = out_valid_q;
        out_load_d   = out_load_q;
        out_alu_d    = out_alu_q;
        out_rd_d     = out_rd_q;
        out_rw_d     = out_rw_q;
        out_m2r_d    = out_m2r_q;
        out_mis_d    = out_mis_q;

        case (state_q)
            IDLE: begin
                if (start_c) begin
                    stall_c      = 1'b1;
                    state_d      = ACCESS;
                    req_we_d     = inMemWrite;
                    req_addr_d   = inAluResult;
                    req_size_d   = inMemSize;
                    req_signed_d = inLoadSigned;
                    req_wdata_d  = st_wdata_c;
                    req_be_d     = st_be_c;
                    req_rd_d     = inMuxRtRd;
                    req_rw_d     = inRegWrite;
                    req_m2r_d    = inMemtoReg;
                    out_valid_d  = 1'b0;
                end else begin
                    out_valid_d = inValid;
                    out_load_d  = '0;
                    out_alu_d   = 32'(inAluResult);
                    out_rd_d    = inMuxRtRd;
                    out_rw_d    = inValid & inRegWrite & ~mis_c;
                    out_m2r_d   = inMemtoReg;
                    out_mis_d   = mis_c;
                end
            end
            ACCESS: begin
                stall_c = ~dmemAck;
                if (dmemAck) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b1;
                    out_load_d  = req_we_q ? '0 : ld_ext_c;
                    out_alu_d   = 32'(req_addr_q);
                    out_rd_d    = req_rd_q;
                    out_rw_d    = req_rw_q;
                    out_m2r_d   = req_m2r_q;
                    out_mis_d   = 1'b0;
                end else begin
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            req_we_q     <= 1'b0;
            req_addr_q   <= '0;
            req_size_q   <= '0;
            req_signed_q <= 1'b0;
            req_wdata_q  <= '0;
            req_be_q     <= '0;
            req_rd_q     <= '0;
            req_rw_q     <= 1'b0;
            req_m2r_q    <= '0;
            out_valid_q  <= 1'b0;
            out_load_q   <= '0;
            out_alu_q    <= '0;
            out_rd_q     <= '0;
            out_rw_q     <= 1'b0;
            out_m2r_q    <= '0;
            out_mis_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_we_q     <= req_we_d;
            req_addr_q   <= req_addr_d;
            req_size_q   <= req_size_d;
            req_signed_q <= req_signed_d;
            req_wdata_q  <= req_wdata_d;
            req_be_q     <= req_be_d;
            req_rd_q     <= req_rd_d;
            req_rw_q     <= req_rw_d;
            req_m2r_q    <= req_m2r_d;
            out_valid_q  <= out_valid_d;
            out_load_q   <= out_load_d;
            out_alu_q    <= out_alu_d;
            out_rd_q     <= out_rd_d;
            out_rw_q     <= out_rw_d;
            out_m2r_q    <= out_m2r_d;
            out_mis_q    <= out_mis_d;
        end
    end

    // Stall is combinational so upstream holds in the same cycle; forced low in reset
    assign outStall   = rst_n & stall_c;
    assign dmemReq    = (state_q == ACCESS);
    assign dmemWe     = req_we_q;
    assign dmemAddr   = {req_addr_q[ADDR_W-1:2], 2'b00};
    assign dmemWdata  = req_wdata_q;
    assign dmemByteEn = req_be_q;

    assign outValid              = out_valid_q;
    assign outLoadWordDividerMEM = out_load_q;
    assign outAluLatch           = out_alu_q;
    assign outMuxRtRd            = out_rd_q;
    assign outRegWrite           = out_rw_q;
    assign outMemtoReg           = out_m2r_q;
    assign outMisaligned         = out_mis_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: expected results are queued as each op is
// driven and compared in order as the stage reports outValid.
module tb_mem_access_stage;

    typedef struct packed {
        logic [31:0] load;
        logic [31:0] alu;
        logic [4:0]  rd;
        logic        rw;
        logic [1:0]  m2r;
        logic        mis;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        inValid, inMemRead, inMemWrite, inLoadSigned, inRegWrite;
    logic [1:0]  inMemSize, inMemtoReg;
    logic [31:0] inAluResult, inStoreData;
    logic [4:0]  inMuxRtRd;
    logic        dmemReq, dmemWe, dmemAck;
    logic [31:0] dmemAddr, dmemWdata, dmemRdata;
    logic [3:0]  dmemByteEn;
    logic        outStall, outValid, outRegWrite, outMisaligned;
    logic [31:0] outLoadWordDividerMEM, outAluLatch;
    logic [4:0]  outMuxRtRd;
    logic [1:0]  outMemtoReg;

    int n_checks = 0;
    int n_fails  = 0;
    res_t sb[$];
    res_t obsq[$];

    always #5 clk = ~clk;

    mem_access_stage #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .inValid(inValid), .inMemRead(inMemRead), .inMemWrite(inMemWrite),
        .inMemSize(inMemSize), .inLoadSigned(inLoadSigned), .inAluResult(inAluResult),
        .inStoreData(inStoreData), .inMuxRtRd(inMuxRtRd), .inRegWrite(inRegWrite),
        .inMemtoReg(inMemtoReg),
        .dmemReq(dmemReq), .dmemWe(dmemWe), .dmemAddr(dmemAddr), .dmemWdata(dmemWdata),
        .dmemByteEn(dmemByteEn), .dmemRdata(dmemRdata), .dmemAck(dmemAck),
        .outStall(outStall), .outValid(outValid),
        .outLoadWordDividerMEM(outLoadWordDividerMEM), .outAluLatch(outAluLatch),
        .outMuxRtRd(outMuxRtRd), .outRegWrite(outRegWrite), .outMemtoReg(outMemtoReg),
        .outMisaligned(outMisaligned)
    );

    task automatic set_op(input logic v, input logic rd_, input logic wr, input logic [1:0] sz,
                          input logic sg, input logic [31:0] a, input logic [31:0] sd,
                          input logic [4:0] rdst, input logic rw, input logic [1:0] m2r);
        inValid = v; inMemRead = rd_; inMemWrite = wr; inMemSize = sz; inLoadSigned = sg;
        inAluResult = a; inStoreData = sd; inMuxRtRd = rdst; inRegWrite = rw; inMemtoReg = m2r;
    endtask

    task automatic drive_idle();
        set_op(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 2'b00);
    endtask

    // Plays the memory side for the op currently on the inputs (driven just after a negedge)
    // and returns what the stage produced once outValid rises.
    task automatic run_access(input int waits, input logic [31:0] rdata, output res_t obs,
                              output int stalls, output int lat, output logic saw_req,
                              output logic [31:0] q_addr, output logic [31:0] q_wdata,
                              output logic [3:0] q_be, output logic q_we, output logic to);
        int acc = 0;
        logic done = 1'b0;
        stalls = 0; lat = 0; saw_req = 1'b0; obs = '0;
        q_addr = '0; q_wdata = '0; q_be = '0; q_we = 1'b0;
        for (int c = 0; c < waits + 8 && !done; c++) begin
            #1;
            if (dmemReq) begin
                saw_req = 1'b1;
                q_addr = dmemAddr; q_wdata = dmemWdata; q_be = dmemByteEn; q_we = dmemWe;
                if (acc == waits) begin
                    dmemAck = 1'b1;
                    dmemRdata = rdata;
                end
                acc++;
            end
            #1;
            if (outStall) stalls++;
            @(posedge clk);
            lat++;
            @(negedge clk);
            dmemAck = 1'b0;
            if (outValid) begin
                done = 1'b1;
                obs = {outLoadWordDividerMEM, outAluLatch, outMuxRtRd, outRegWrite,
                       outMemtoReg, outMisaligned};
            end
        end
        to = ~done;
    endtask

    task automatic test_reset_init();
        set_op(1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 32'h100, 32'h0, 5'd3, 1'b1, 2'b01);
        #1;
        n_checks++;
        if ({outValid, outLoadWordDividerMEM, outAluLatch, outMuxRtRd, outRegWrite,
             outMemtoReg, outMisaligned} !== '0) begin
            n_fails++;
            $display("FAIL reset_outputs: got valid=%b alu=%h rd=%0d rw=%b", outValid,
                     outAluLatch, outMuxRtRd, outRegWrite);
        end
        n_checks++;
        if (dmemReq !== 1'b0 || outStall !== 1'b0) begin
            n_fails++;
            $display("FAIL reset_req_stall: got req=%b stall=%b, expected 0 0", dmemReq, outStall);
        end
        @(negedge clk);
        drive_idle();
        rst_n = 1'b1;
    endtask

    task automatic test_alu();
        res_t e, obs;
        int stalls, lat;
        logic saw, we, to;
        logic [31:0] a, wd;
        logic [3:0] be;
        @(negedge clk);
        set_op(1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 32'h1234, 32'hFFFF_FFFF, 5'd5, 1'b1, 2'b01);
        sb.push_back('{load: 32'h0, alu: 32'h1234, rd: 5'd5, rw: 1'b1, m2r: 2'b01, mis: 1'b0});
        run_access(0, 32'h0, obs, stalls, lat, saw, a, wd, be, we, to);
        e = sb.pop_front();
        n_checks++;
        if (to || obs !== e) begin
            n_fails++;
            $display("FAIL alu_result: got %h expected %h (timeout=%b)", obs, e, to);
        end
        n_checks++;
        if (stalls != 0 || saw || lat != 1) begin
            n_fails++;
            $display("FAIL alu_timing: got stalls=%0d req=%b lat=%0d expected 0 0 1", stalls, saw, lat);
        end
        set_op(1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 32'h77, 32'h0, 5'd6, 1'b1, 2'b00);
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (outValid !== 1'b0 || outRegWrite !== 1'b0) begin
            n_fails++;
            $display("FAIL bubble: got valid=%b rw=%b expected 0 0", outValid, outRegWrite);
        end
        drive_idle();
    endtask

    task automatic test_reset_mid();
        logic bad = 1'b0;
        @(negedge clk);
        set_op(1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 32'h55, 32'h0, 5'd9, 1'b1, 2'b10);
        @(negedge clk);
        set_op(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 32'h100, 32'h0, 5'd9, 1'b1, 2'b01);
        @(negedge clk);
        #1;
        n_checks++;
        if (dmemReq !== 1'b1 || outStall !== 1'b1) begin
            n_fails++;
            $display("FAIL mid_access: got req=%b stall=%b expected 1 1", dmemReq, outStall);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (dmemReq !== 1'b0 || outStall !== 1'b0 ||
            {outValid, outLoadWordDividerMEM, outAluLatch, outMuxRtRd, outRegWrite,
             outMemtoReg, outMisaligned} !== '0) begin
            n_fails++;
            $display("FAIL mid_reset: got req=%b stall=%b alu=%h rd=%0d expected all 0",
                     dmemReq, outStall, outAluLatch, outMuxRtRd);
        end
        @(negedge clk);
        drive_idle();
        rst_n = 1'b1;
        dmemAck = 1'b1;
        dmemRdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            dmemAck = 1'b0;
            if (outValid !== 1'b0 || dmemReq !== 1'b0) bad = 1'b1;
        end
        n_checks++;
        if (bad) begin
            n_fails++;
            $display("FAIL stray_ack: got valid=%b req=%b expected 0 0", outValid, dmemReq);
        end
    endtask

    task automatic test_byte_load();
        res_t e, obs;
        int stalls, lat;
        logic saw, we, to;
        logic [31:0] a, wd;
        logic [3:0] be;
        @(negedge clk);
        set_op(1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 5'd7, 1'b1, 2'b10);
        sb.push_back('{load: 32'hFFFF_FF80, alu: 32'h103, rd: 5'd7, rw: 1'b1, m2r: 2'b10, mis: 1'b0});
        run_access(3, 32'h80FF_0000, obs, stalls, lat, saw, a, wd, be, we, to);
        drive_idle();
        e = sb.pop_front();
        n_checks++;
        if (to || obs !== e) begin
            n_fails++;
            $display("FAIL byte_load_result: got %h expected %h (timeout=%b)", obs, e, to);
        end
        n_checks++;
        if (stalls != 4 || lat != 5) begin
            n_fails++;
            $display("FAIL byte_load_timing: got stalls=%0d lat=%0d expected 4 5", stalls, lat);
        end
        n_checks++;
        if (a !== 32'h100 || we !== 1'b0) begin
            n_fails++;
            $display("FAIL byte_load_req: got addr=%h we=%b expected 00000100 0", a, we);
        end
    endtask

    task automatic test_half_load();
        res_t e, obs;
        int stalls, lat;
        logic saw, we, to;
        logic [31:0] a, wd;
        logic [3:0] be;
        @(negedge clk);
        set_op(1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 32'h202, 32'h0, 5'd8, 1'b1, 2'b10);
        sb.push_back('{load: 32'h0000_BEEF, alu: 32'h202, rd: 5'd8, rw: 1'b1, m2r: 2'b10, mis: 1'b0});
        run_access(0, 32'hBEEF_1234, obs, stalls, lat, saw, a, wd, be, we, to);
        drive_idle();
        e = sb.pop_front();
        n_checks++;
        if (to || obs !== e) begin
            n_fails++;
            $display("FAIL half_load_result: got %h expected %h (timeout=%b)", obs, e, to);
        end
        n_checks++;
        if (lat != 2 || stalls != 1 || a !== 32'h200) begin
            n_fails++;
            $display("FAIL half_load_timing: got lat=%0d stalls=%0d addr=%h expected 2 1 00000200",
                     lat, stalls, a);
        end
    endtask

    task automatic test_store();
        res_t e, obs;
        int stalls, lat;
        logic saw, we, to;
        logic [31:0] a, wd;
        logic [3:0] be;
        @(negedge clk);
        set_op(1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 32'h301, 32'h0000_00AB, 5'd0, 1'b0, 2'b00);
        sb.push_back('{load: 32'h0, alu: 32'h301, rd: 5'd0, rw: 1'b0, m2r: 2'b00, mis: 1'b0});
        run_access(1, 32'h1111_1111, obs, stalls, lat, saw, a, wd, be, we, to);
        drive_idle();
        e = sb.pop_front();
        n_checks++;
        if (to || obs !== e) begin
            n_fails++;
            $display("FAIL byte_store_result: got %h expected %h (timeout=%b)", obs, e, to);
        end
        n_checks++;
        if (we !== 1'b1 || be !== 4'b0010 || wd !== 32'hABAB_ABAB || a !== 32'h300) begin
            n_fails++;
            $display("FAIL byte_store_req: got we=%b be=%b wdata=%h addr=%h expected 1 0010 ababab ab 300",
                     we, be, wd, a);
        end
        // read and write both set: must behave as a store
        @(negedge clk);
        set_op(1'b1, 1'b1, 1'b1, 2'b01, 1'b1, 32'h302, 32'h1234_CDEF, 5'd2, 1'b0, 2'b00);
        sb.push_back('{load: 32'h0, alu: 32'h302, rd: 5'd2, rw: 1'b0, m2r: 2'b00, mis: 1'b0});
        run_access(0, 32'h8888_8888, obs, stalls, lat, saw, a, wd, be, we, to);
        drive_idle();
        e = sb.pop_front();
        n_checks++;
        if (to || obs !== e) begin
            n_fails++;
            $display("FAIL half_store_result: got %h expected %h (timeout=%b)", obs, e, to);
        end
        n_checks++;
        if (we !== 1'b1 || be !== 4'b1100 || wd !== 32'hCDEF_CDEF) begin
            n_fails++;
            $display("FAIL half_store_req: got we=%b be=%b wdata=%h expected 1 1100 cdefcdef", we, be, wd);
        end
    endtask

    task automatic test_misaligned();
        res_t e, obs;
        int stalls, lat;
        logic saw, we, to;
        logic [31:0] a, wd;
        logic [3:0] be;
        @(negedge clk);
        set_op(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h402, 32'h0, 5'd4, 1'b1, 2'b10);
        sb.push_back('{load: 32'h0, alu: 32'h402, rd: 5'd4, rw: 1'b0, m2r: 2'b10, mis: 1'b1});
        run_access(0, 32'hFFFF_FFFF, obs, stalls, lat, saw, a, wd, be, we, to);
        drive_idle();
        e = sb.pop_front();
        n_checks++;
        if (to || obs !== e) begin
            n_fails++;
            $display("FAIL misaligned_result: got %h expected %h (timeout=%b)", obs, e, to);
        end
        n_checks++;
        if (saw || stalls != 0 || lat != 1) begin
            n_fails++;
            $display("FAIL misaligned_timing: got req=%b stalls=%0d lat=%0d expected 0 0 1", saw, stalls, lat);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs[3] = '{32'h500, 32'h200, 32'h601};
        logic [31:0] rdat[3]  = '{32'hDEAD_BEEF, 32'h1234_8001, 32'h0000_F000};
        logic [1:0]  sizes[3] = '{2'b10, 2'b01, 2'b00};
        logic        sgn[3]   = '{1'b1, 1'b1, 1'b0};
        logic [31:0] exps[3]  = '{32'hDEAD_BEEF, 32'hFFFF_8001, 32'h0000_00F0};
        res_t e, obs;
        int stalls, lat;
        int bad_lat = 0;
        logic saw, we, to;
        logic [31:0] a, wd;
        logic [3:0] be;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            set_op(1'b1, 1'b1, 1'b0, sizes[i], sgn[i], addrs[i], 32'h0, 5'(i + 1), 1'b1, 2'b01);
            sb.push_back('{load: exps[i], alu: addrs[i], rd: 5'(i + 1), rw: 1'b1, m2r: 2'b01, mis: 1'b0});
            run_access(0, rdat[i], obs, stalls, lat, saw, a, wd, be, we, to);
            if (to) obs = '1;
            if (lat != 2) bad_lat++;
            obsq.push_back(obs);
        end
        drive_idle();
        for (int i = 0; i < 3; i++) begin
            e = sb.pop_front();
            obs = obsq.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fails++;
                $display("FAIL b2b_result_%0d: got %h expected %h", i, obs, e);
            end
        end
        n_checks++;
        if (bad_lat != 0) begin
            n_fails++;
            $display("FAIL b2b_latency: got %0d ops with latency other than 2, expected 0", bad_lat);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        dmemAck = 1'b0;
        dmemRdata = 32'h0;
        drive_idle();
        repeat (2) @(negedge clk);
        test_reset_init();
        test_alu();
        test_reset_mid();
        test_byte_load();
        test_half_load();
        test_store();
        test_misaligned();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
